// File: rtl/memory_stage.sv
// Memory stage of the pipeline. It issues one cache access or flush at a
// time, stalls upstream while the cache is busy, and drives the registered
// writeback outputs. A halt request parks the stage until reset.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no cache request pending; ALU results pass to writeback
// ACCESS | load/store issued, waiting for iDcDone
// FLUSH  | cache flush issued, waiting for iDcDone
// HALT   | processor halted; stall held until reset
module memory_stage (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [31:0] iAddr,
    input  logic [31:0] iMemData,
    input  logic        iMemValid,
    input  logic        iMemWrite,
    input  logic        iMemToReg,
    input  logic        iCacheFlush,
    input  logic        iHalt,
    input  logic [4:0]  iWriteAddr,
    input  logic        iWriteEn,
    input  logic [31:0] iDcRdData,
    input  logic        iDcDone,
    output logic [31:0] oDcAddr,
    output logic [31:0] oDcWrData,
    output logic        oDcRd,
    output logic        oDcWr,
    output logic        oDcFlush,
    output logic        oStall,
    output logic [31:0] oFwdMem,
    output logic [31:0] oWbData,
    output logic [4:0]  oWbAddr,
    output logic        oWbEn,
    output logic        oHalted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FLUSH  = 2'd2,
        HALT   = 2'd3
    } stateT;

    stateT       state;
    stateT       stateNext;

    // Attributes of the access in flight, needed when the cache completes.
    logic        opMemToReg;
    logic        opWriteEn;
    logic [4:0]  opWriteAddr;

    // The execution result is forwarded unregistered.
    assign oFwdMem = iAddr;

    // State register.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and stall decode; a flush wins over a simultaneous access.
    always_comb begin
        stateNext = state;
        oStall    = 1'b0;
        case (state)
            IDLE: begin
                if (iCacheFlush) begin
                    stateNext = FLUSH;
                    oStall    = 1'b1;
                end else if (iMemValid) begin
                    stateNext = ACCESS;
                    oStall    = 1'b1;
                end else if (iHalt) begin
                    stateNext = HALT;
                end
            end
            ACCESS: begin
                oStall = !iDcDone;
                if (iDcDone) begin
                    stateNext = IDLE;
                end
            end
            FLUSH: begin
                oStall = !iDcDone;
                if (iDcDone) begin
                    stateNext = IDLE;
                end
            end
            HALT: begin
                oStall = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Cache request, captured operation and writeback registers. Every
    // stalled cycle other than the completion cycle loads a bubble so a
    // held instruction never writes the register file twice.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            oDcAddr     <= 32'd0;
            oDcWrData   <= 32'd0;
            oDcRd       <= 1'b0;
            oDcWr       <= 1'b0;
            oDcFlush    <= 1'b0;
            opMemToReg  <= 1'b0;
            opWriteEn   <= 1'b0;
            opWriteAddr <= 5'd0;
            oWbData     <= 32'd0;
            oWbAddr     <= 5'd0;
            oWbEn       <= 1'b0;
            oHalted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iCacheFlush) begin
                        oDcFlush <= 1'b1;
                        oWbEn    <= 1'b0;
                    end else if (iMemValid) begin
                        oDcAddr     <= iAddr;
                        oDcWrData   <= iMemData;
                        oDcRd       <= !iMemWrite;
                        oDcWr       <= iMemWrite;
                        opMemToReg  <= iMemToReg;
                        opWriteEn   <= iWriteEn;
                        opWriteAddr <= iWriteAddr;
                        oWbEn       <= 1'b0;
                    end else begin
                        oWbData <= iAddr;
                        oWbAddr <= iWriteAddr;
                        oWbEn   <= iWriteEn;
                        oHalted <= iHalt;
                    end
                end
                ACCESS: begin
                    if (iDcDone) begin
                        oDcRd   <= 1'b0;
                        oDcWr   <= 1'b0;
                        oWbData <= opMemToReg ? iDcRdData : oDcAddr;
                        oWbAddr <= opWriteAddr;
                        oWbEn   <= opWriteEn;
                    end else begin
                        oWbEn <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (iDcDone) begin
                        oDcFlush <= 1'b0;
                    end
                    oWbEn <= 1'b0;
                end
                default: begin
                    oDcRd    <= 1'b0;
                    oDcWr    <= 1'b0;
                    oDcFlush <= 1'b0;
                    oWbEn    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic, every
// cycle compared against a transaction-level model of the stage.
module tb_memory_stage;

    logic        iClk;
    logic        iRst_n;
    logic [31:0] iAddr;
    logic [31:0] iMemData;
    logic        iMemValid;
    logic        iMemWrite;
    logic        iMemToReg;
    logic        iCacheFlush;
    logic        iHalt;
    logic [4:0]  iWriteAddr;
    logic        iWriteEn;
    logic [31:0] iDcRdData;
    logic        iDcDone;
    logic [31:0] oDcAddr;
    logic [31:0] oDcWrData;
    logic        oDcRd;
    logic        oDcWr;
    logic        oDcFlush;
    logic        oStall;
    logic [31:0] oFwdMem;
    logic [31:0] oWbData;
    logic [4:0]  oWbAddr;
    logic        oWbEn;
    logic        oHalted;

    memory_stage dut (
        .iClk(iClk), .iRst_n(iRst_n), .iAddr(iAddr), .iMemData(iMemData),
        .iMemValid(iMemValid), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
        .iCacheFlush(iCacheFlush), .iHalt(iHalt), .iWriteAddr(iWriteAddr),
        .iWriteEn(iWriteEn), .iDcRdData(iDcRdData), .iDcDone(iDcDone),
        .oDcAddr(oDcAddr), .oDcWrData(oDcWrData), .oDcRd(oDcRd), .oDcWr(oDcWr),
        .oDcFlush(oDcFlush), .oStall(oStall), .oFwdMem(oFwdMem),
        .oWbData(oWbData), .oWbAddr(oWbAddr), .oWbEn(oWbEn), .oHalted(oHalted)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int vecCnt = 0;
    int errCnt = 0;

    // Model: pending cache work (0 none, 1 load, 2 store, 3 flush).
    int          pend;
    logic [31:0] mAddr, mData;
    logic        mM2R, mWe, mHalted;
    logic [4:0]  mWa;
    logic [31:0] eWbData;
    logic [4:0]  eWbAddr;
    logic        eWbEn;

    int stallSeen, rdSeen, wrSeen, flushSeen, wbSeen;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        pend = 0; mAddr = 0; mData = 0; mM2R = 0; mWe = 0; mWa = 0;
        mHalted = 0; eWbData = 0; eWbAddr = 0; eWbEn = 0;
    endtask

    task automatic modelEdge();
        if (!iRst_n) begin
            modelReset();
        end else if (mHalted) begin
            eWbEn = 0;
        end else if (pend == 0) begin
            if (iCacheFlush) begin
                pend = 3; eWbEn = 0;
            end else if (iMemValid) begin
                pend = iMemWrite ? 2 : 1;
                mAddr = iAddr; mData = iMemData; mM2R = iMemToReg;
                mWa = iWriteAddr; mWe = iWriteEn; eWbEn = 0;
            end else begin
                eWbData = iAddr; eWbAddr = iWriteAddr; eWbEn = iWriteEn;
                mHalted = iHalt;
            end
        end else if (iDcDone) begin
            if (pend != 3) begin
                eWbData = mM2R ? iDcRdData : mAddr;
                eWbAddr = mWa; eWbEn = mWe;
            end else begin
                eWbEn = 0;
            end
            pend = 0;
        end else begin
            eWbEn = 0;
        end
    endtask

    // One cycle: inputs already driven after a falling edge.
    task automatic step();
        logic expStall;
        #1;
        if (mHalted) expStall = 1'b1;
        else if (pend != 0) expStall = !iDcDone;
        else expStall = iCacheFlush | iMemValid;
        checkVal("stall", {31'd0, oStall}, {31'd0, expStall});
        checkVal("fwd", oFwdMem, iAddr);
        stallSeen += oStall;
        @(posedge iClk);
        modelEdge();
        @(negedge iClk);
        checkVal("dcAddr", oDcAddr, mAddr);
        checkVal("dcWrData", oDcWrData, mData);
        checkVal("dcRd", {31'd0, oDcRd}, {31'd0, pend == 1});
        checkVal("dcWr", {31'd0, oDcWr}, {31'd0, pend == 2});
        checkVal("dcFlush", {31'd0, oDcFlush}, {31'd0, pend == 3});
        checkVal("wbData", oWbData, eWbData);
        checkVal("wbAddr", {27'd0, oWbAddr}, {27'd0, eWbAddr});
        checkVal("wbEn", {31'd0, oWbEn}, {31'd0, eWbEn});
        checkVal("halted", {31'd0, oHalted}, {31'd0, mHalted});
        rdSeen += oDcRd; wrSeen += oDcWr; flushSeen += oDcFlush; wbSeen += oWbEn;
    endtask

    task automatic idleInputs();
        iRst_n = 1; iAddr = 0; iMemData = 0; iMemValid = 0; iMemWrite = 0;
        iMemToReg = 0; iCacheFlush = 0; iHalt = 0; iWriteAddr = 0;
        iWriteEn = 0; iDcRdData = 0; iDcDone = 0;
    endtask

    task automatic clearSeen();
        stallSeen = 0; rdSeen = 0; wrSeen = 0; flushSeen = 0; wbSeen = 0;
    endtask

    task automatic doReset();
        idleInputs();
        iRst_n = 0;
        step();
        iRst_n = 1;
    endtask

    initial begin
        idleInputs();
        iRst_n = 0;
        modelReset();
        clearSeen();
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        checkVal("rst wbEn", {31'd0, oWbEn}, 32'd0);
        checkVal("rst halted", {31'd0, oHalted}, 32'd0);
        checkVal("rst dcAddr", oDcAddr, 32'd0);
        checkVal("rst stall", {31'd0, oStall}, 32'd0);

        // ALU op
        idleInputs();
        clearSeen();
        iAddr = 32'h0000_1234; iWriteAddr = 5'd5; iWriteEn = 1;
        step();
        checkVal("alu wbData", oWbData, 32'h0000_1234);
        checkVal("alu wbAddr", {27'd0, oWbAddr}, 32'd5);
        checkVal("alu wbEn", {31'd0, oWbEn}, 32'd1);
        checkVal("alu stallCnt", stallSeen, 0);

        // Load, done three cycles after capture
        idleInputs();
        clearSeen();
        iAddr = 32'h100; iMemValid = 1; iMemToReg = 1; iWriteAddr = 5'd3; iWriteEn = 1;
        step(); step(); step();
        iDcDone = 1; iDcRdData = 32'hDEAD_BEEF;
        step();
        checkVal("load wbData", oWbData, 32'hDEAD_BEEF);
        idleInputs();
        step();
        checkVal("load rdCnt", rdSeen, 3);
        checkVal("load stallCnt", stallSeen, 3);
        checkVal("load wbCnt", wbSeen, 1);

        // Store without writeback
        idleInputs();
        clearSeen();
        iAddr = 32'h200; iMemData = 32'hA5A5_A5A5; iMemValid = 1; iMemWrite = 1;
        step();
        iAddr = 32'h0BAD; iMemData = 32'h0;
        step(); step();
        checkVal("store dcAddr", oDcAddr, 32'h200);
        checkVal("store dcWrData", oDcWrData, 32'hA5A5_A5A5);
        iDcDone = 1;
        step();
        idleInputs();
        step();
        checkVal("store wrCnt", wrSeen, 3);
        checkVal("store wbCnt", wbSeen, 0);

        // Flush together with an access
        idleInputs();
        clearSeen();
        iCacheFlush = 1; iMemValid = 1; iAddr = 32'h300;
        step(); step();
        iDcDone = 1;
        step();
        idleInputs();
        step();
        checkVal("flush flushCnt", flushSeen, 2);
        checkVal("flush rdCnt", rdSeen + wrSeen, 0);
        checkVal("flush stall", {31'd0, oStall}, 32'd0);

        // Halt presented with a load, then on its own
        idleInputs();
        clearSeen();
        iAddr = 32'h40; iMemValid = 1; iMemToReg = 1; iWriteAddr = 5'd7;
        iWriteEn = 1; iHalt = 1;
        step(); step();
        iDcDone = 1; iDcRdData = 32'h1357_9BDF;
        step();
        checkVal("halt load wbData", oWbData, 32'h1357_9BDF);
        idleInputs();
        iHalt = 1;
        step();
        clearSeen();
        for (int i = 0; i < 12; i++) begin
            idleInputs();
            iDcDone = (i % 3 == 0);
            iMemValid = (i % 4 == 1);
            step();
        end
        checkVal("halt stallCnt", stallSeen, 12);
        checkVal("halt halted", {31'd0, oHalted}, 32'd1);
        checkVal("halt wbCnt", wbSeen + rdSeen + wrSeen + flushSeen, 0);
        doReset();

        // Reset mid-access, late done afterwards
        idleInputs();
        iAddr = 32'h500; iMemValid = 1; iWriteAddr = 5'd9; iWriteEn = 1;
        step(); step();
        iRst_n = 0;
        step();
        idleInputs();
        clearSeen();
        iDcDone = 1; iDcRdData = 32'hFFFF_FFFF;
        step();
        checkVal("abort dcAddr", oDcAddr, 32'd0);
        checkVal("abort wbEn", {31'd0, oWbEn}, 32'd0);
        checkVal("abort wbData", oWbData, 32'd0);
        checkVal("abort stallCnt", stallSeen, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            iRst_n      = ($urandom_range(0, 39) != 0);
            if (mHalted && $urandom_range(0, 7) == 0) iRst_n = 0;
            iAddr       = $urandom;
            iMemData    = $urandom;
            iMemValid   = ($urandom_range(0, 2) == 0);
            iMemWrite   = $urandom_range(0, 1);
            iMemToReg   = $urandom_range(0, 1);
            iCacheFlush = ($urandom_range(0, 11) == 0);
            iHalt       = ($urandom_range(0, 59) == 0);
            iWriteAddr  = 5'($urandom);
            iWriteEn    = $urandom_range(0, 1);
            iDcRdData   = $urandom;
            iDcDone     = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
